// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Purpose:
//   Iterative AES-128 encryption sequencer. Takes one plaintext block per
//   handshake, performs the initial key whitening itself, then walks an
//   external single-round combinational datapath through NR rounds (one per
//   clock) and presents the ciphertext on a valid/ready output. This block
//   owns the only state register and round counter in the encryption path.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    synchronous active-low reset
//   abort      in   1    (AES_ABORT_EN builds only) drop the block in flight
//   in_valid   in   1    plaintext offered
//   in_ready   out  1    accepting plaintext (IDLE only)
//   in_blk     in   128  plaintext, byte 0 = in_blk[7:0], column-major
//   rk_idx     out  4    round-key index requested from the key schedule
//   rk         in   128  round key for rk_idx (combinational lookup)
//   rnd_state  out  128  state register, fed to the round datapath
//   rnd_last   out  1    final round, datapath skips mixColumns
//   rnd_result in   128  round datapath output, already XORed with rk
//   out_valid  out  1    ciphertext available
//   out_ready  in   1    ciphertext consumed
//   out_blk    out  128  ciphertext (the state register)
//   busy       out  1    high in every state except IDLE
//
// Build option:
//   AES_ABORT_EN  adds the abort input; undefined gives the reset-only build.
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_blk,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] rnd_state,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_blk,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(NR);

  logic [1:0]   r_fsm;
  logic [3:0]   r_round;
  logic [127:0] r_state;

  logic         w_abort;
  logic         w_roundBad;
  logic         w_inRound;

  // The abort request only exists in the abort-enabled build; the default
  // build ties it off so the sequencing logic below is identical in both.
`ifdef AES_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // The counter can never legally pass the last round, so any larger value
  // means the register was upset and the block in flight is meaningless.
  assign w_roundBad = (r_round > LAST_RND);
  assign w_inRound  = (r_fsm == S_ROUND);

  // Main sequencer. IDLE whitens the accepted plaintext with round key 0,
  // ROUND captures one datapath result per clock, DONE holds the ciphertext
  // until the consumer takes it. Reset, abort (outside IDLE) and a corrupted
  // counter all funnel into the same cleared IDLE condition so a discarded
  // block can never leak out as an output pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_round <= 4'd0;
      r_state <= '0;
    end else if (w_roundBad || (w_abort && (r_fsm != S_IDLE))) begin
      r_fsm   <= S_IDLE;
      r_round <= 4'd0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= in_blk ^ rk;
            r_round <= 4'd1;
            r_fsm   <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= rnd_result;
          if (r_round == LAST_RND) begin
            r_fsm <= S_DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_fsm   <= S_IDLE;
            r_round <= 4'd0;
          end
        end
        default: begin
          r_fsm   <= S_IDLE;
          r_round <= 4'd0;
          r_state <= '0;
        end
      endcase
    end
  end

  // Every output is a decode of registered state only, so the key-schedule
  // lookup and both handshakes have no combinational path from the inputs.
  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign rk_idx    = w_inRound ? r_round : 4'd0;
  assign rnd_last  = w_inRound && (r_round == LAST_RND);
  assign rnd_state = r_state;
  assign out_blk   = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_blk;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] rnd_state;
  logic         rnd_last;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_blk;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  int readyMode = 0;

  logic [127:0] expQ[$];
  int           acceptQ[$];

  logic [127:0] curKey;
  logic [127:0] roundKeys [0:10];
  logic [3:0]   keySel;

  aes_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AES_ABORT_EN
    .abort      (abort),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_blk     (in_blk),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .rnd_state  (rnd_state),
    .rnd_last   (rnd_last),
    .rnd_result (rnd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_blk    (out_blk),
    .busy       (busy)
  );

  // Free-running clock and an edge counter used to time accepts and outputs.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // ---------------- AES arithmetic (byte 0 = bits [7:0]) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] st,
                                            input logic [127:0] key,
                                            input logic last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = t[i];
    return res ^ key;
  endfunction

  function automatic logic [127:0] roundKey(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[7:0], tmp[31:8]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {24'h0, rcon};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*n+3], w[4*n+2], w[4*n+1], w[4*n]};
  endfunction

  // Reference model: the whole cipher for one block, independent of timing.
  function automatic logic [127:0] aesEncrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] st;
    st = pt ^ roundKey(key, 0);
    for (int r = 1; r <= 10; r++) st = aesRound(st, roundKey(key, r), r == 10);
    return st;
  endfunction

  function automatic logic [127:0] byteRev(input logic [127:0] h);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = h[8*(15-i) +: 8];
    return o;
  endfunction

  // Stand-ins for the team's key schedule and single-round datapath.
  assign keySel = (rk_idx > 4'd10) ? 4'd0 : rk_idx;
  assign rk     = roundKeys[keySel];

  always_comb rnd_result = aesRound(rnd_state, rk, rnd_last);

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycleCnt);
  endtask

  task automatic setKey(input logic [127:0] key);
    curKey = key;
    for (int n = 0; n <= 10; n++) roundKeys[n] = roundKey(key, n);
  endtask

  // Offers one block from a negedge; records its expected ciphertext and
  // accept edge once the DUT is seen ready, then returns one cycle later.
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] exp, output int acceptEdge);
    int n;
    n = 0;
    acceptEdge = -1;
    in_valid = 1'b1;
    in_blk = pt;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      failTimeout("accept");
      in_valid = 1'b0;
    end else begin
      expQ.push_back(exp);
      acceptEdge = cycleCnt + 1;
      acceptQ.push_back(acceptEdge);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0 || busy) failTimeout("drain");
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Consumer side: out_ready changes shortly after each rising edge.
  initial begin : readyDriver
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks the accept-to-valid latency on each rising out_valid and
  // pops the scoreboard on every output transfer.
  initial begin : monitor
    logic prevValid;
    int   a;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && !prevValid) begin
        if (acceptQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL latency: out_valid rose at cycle %0d, required no output", cycleCnt);
        end else begin
          a = acceptQ.pop_front();
          checkOutput("latency", 128'(cycleCnt - a), 128'(10));
        end
      end
      prevValid = out_valid;
      if (out_valid && out_ready && !abort) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL output: transfer of %h, required none", out_blk);
        end else begin
          checkOutput("ciphertext", out_blk, expQ.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized run against the model.
  initial begin : stimulus
    logic [127:0] fKey, fPt, fCt, pt, bpExp;
    int a1, a2, n;

    fKey = byteRev(128'h000102030405060708090a0b0c0d0e0f);
    fPt  = byteRev(128'h00112233445566778899aabbccddeeff);
    fCt  = byteRev(128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_blk = '0;
    setKey(fKey);
    repeat (2) @(negedge clk);
    checkBit("rst in_ready", in_ready, 1'b1);
    checkBit("rst out_valid", out_valid, 1'b0);
    checkBit("rst busy", busy, 1'b0);
    checkOutput("rst rk_idx", 128'(rk_idx), 128'(0));
    checkBit("rst rnd_last", rnd_last, 1'b0);
    checkOutput("rst rnd_state", rnd_state, '0);
    checkOutput("rst out_blk", out_blk, '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] FIPS-197 C.1 vector");
    in_valid = 1'b1; in_blk = fPt;
    checkBit("idle in_ready", in_ready, 1'b1);
    checkOutput("idle rk_idx", 128'(rk_idx), 128'(0));
    expQ.push_back(fCt);
    acceptQ.push_back(cycleCnt + 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      checkOutput("round rk_idx", 128'(rk_idx), 128'(k));
      checkBit("round rnd_last", rnd_last, k == 10);
      checkBit("round in_ready", in_ready, 1'b0);
    end
    waitDrain();

    $display("[TB] back-to-back blocks");
    applyStimulus(fPt, fCt, a1);
    applyStimulus(fPt, fCt, a2);
    checkOutput("accept spacing", 128'(a2 - a1), 128'(12));
    waitDrain();

    $display("[TB] backpressure in DONE");
    readyMode = 2;
    @(negedge clk);
    pt = rand128();
    bpExp = aesEncrypt(curKey, pt);
    applyStimulus(pt, bpExp, a1);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) failTimeout("backpressure valid");
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin in_valid = 1'b1; in_blk = rand128(); end
      checkBit("bp out_valid", out_valid, 1'b1);
      checkBit("bp in_ready", in_ready, 1'b0);
      checkOutput("bp out_blk", out_blk, bpExp);
      @(negedge clk);
    end
    in_valid = 1'b0;
    readyMode = 0;
    repeat (2) @(negedge clk);
    checkBit("bp release in_ready", in_ready, 1'b1);
    checkBit("bp release out_valid", out_valid, 1'b0);
    @(negedge clk);
    checkBit("bp no accept", busy, 1'b0);

    $display("[TB] reset mid-operation");
    setKey(rand128());
    pt = rand128();
    applyStimulus(pt, aesEncrypt(curKey, pt), a1);
    repeat (4) @(negedge clk);
    checkOutput("pre-reset rk_idx", 128'(rk_idx), 128'(5));
    rst_n = 1'b0;
    expQ.delete();
    acceptQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    checkBit("mid-rst in_ready", in_ready, 1'b1);
    checkBit("mid-rst busy", busy, 1'b0);
    checkOutput("mid-rst rk_idx", 128'(rk_idx), 128'(0));
    checkBit("mid-rst rnd_last", rnd_last, 1'b0);
    checkOutput("mid-rst rnd_state", rnd_state, '0);
    checkOutput("mid-rst out_blk", out_blk, '0);
    for (int i = 0; i < 12; i++) begin
      checkBit("mid-rst out_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    pt = rand128();
    applyStimulus(pt, aesEncrypt(curKey, pt), a1);
    waitDrain();

`ifdef AES_ABORT_EN
    $display("[TB] abort in ROUND and DONE");
    pt = rand128();
    applyStimulus(pt, aesEncrypt(curKey, pt), a1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    expQ.delete();
    acceptQ.delete();
    @(negedge clk);
    abort = 1'b0;
    checkBit("abort rnd busy", busy, 1'b0);
    checkBit("abort rnd out_valid", out_valid, 1'b0);
    checkOutput("abort rnd state", rnd_state, '0);
    pt = rand128();
    applyStimulus(pt, aesEncrypt(curKey, pt), a1);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) failTimeout("abort done valid");
    abort = 1'b1;
    expQ.delete();
    @(negedge clk);
    abort = 1'b0;
    checkBit("abort done out_valid", out_valid, 1'b0);
    checkBit("abort done in_ready", in_ready, 1'b1);
    checkOutput("abort done out_blk", out_blk, '0);
    abort = 1'b1;
    pt = rand128();
    applyStimulus(pt, aesEncrypt(curKey, pt), a1);
    abort = 1'b0;
    waitDrain();
`endif

    $display("[TB] randomized blocks");
    readyMode = 1;
    for (int b = 0; b < 25; b++) begin
      if (b % 5 == 0) begin
        waitDrain();
        setKey(rand128());
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pt = rand128();
      applyStimulus(pt, aesEncrypt(curKey, pt), a1);
    end
    waitDrain();
    readyMode = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption sequencer. Accepts one 128-bit plaintext block per handshake and drives the team's single-round combinational datapath (subBytes → shiftRows → mixColumns → addRoundKey) once per clock for ten rounds. It requests round keys from the key-schedule block by index and presents the ciphertext on a valid/ready output. It owns the only state register and round counter in the encryption path.

## Interface

Parameters:
- NR, 10, number of rounds; fixed for AES-128 and must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  plaintext block offered.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_blk  input  128  plaintext; byte 0 = in_blk[7:0], column-major, same byte order as shiftRows.
- rk_idx  output  4  round-key index requested from the key schedule, 0..10.
- rk  input  128  round key for rk_idx; combinational, valid in the same cycle.
- rnd_state  output  128  current state register, fed to the round datapath.
- rnd_last  output  1  high in the final round; datapath bypasses mixColumns.
- rnd_result  input  128  combinational round output, already XORed with rk.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  ciphertext consumed when out_valid && out_ready.
- out_blk  output  128  ciphertext; equals the state register while out_valid.
- busy  output  1  high in every state except IDLE.

## Operation

- States: IDLE, ROUND, DONE. All transitions occur on rising clk edges.
- IDLE: in_ready=1, rk_idx=0. On accept: state ← in_blk ^ rk, round ← 1, go to ROUND.
- ROUND: rk_idx=round and rnd_last=(round==NR). Each cycle: state ← rnd_result and round ← round+1. When round==NR, go to DONE instead of incrementing.
- DONE: out_valid=1 and out_blk=state. State and round are held. On out_ready, go to IDLE.
- The round counter is 4 bits wide and never exceeds 10. No wrap. A value above 10 is unreachable; if detected, force IDLE.
- in_ready=0 outside IDLE. A block offered during ROUND or DONE is not accepted and must be held by the source.
- No overlap: a new block is accepted no earlier than the cycle after the DONE handshake.
- rnd_state always equals the state register, including in IDLE and DONE.
- Reset (rst_n=0 at an edge) in any state, including mid-round: go to IDLE with round=0 and state=0. Any in-flight block is discarded and no out_valid pulse is produced.
- Reset values: in_ready=1, out_valid=0, busy=0, rk_idx=0, rnd_last=0, rnd_state=0, out_blk=0.

## Timing

- Accept edge E0. Rounds 1..10 execute on edges E1..E10.
- out_valid rises after E10, i.e. 10 cycles after accept. Minimum block period is 12 cycles (10 rounds + DONE + IDLE).
- out_valid stays high until the cycle in which out_ready=1. It drops after that edge.
- rk_idx and rnd_last are decoded from registered state only, so the key-schedule lookup has no combinational path from inputs.
- in_ready and out_valid are registered-state decodes and have no combinational dependence on in_valid or out_ready.

## Configuration

- AES_ABORT_EN defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in ROUND or DONE forces IDLE at the next edge, with state and round cleared as for reset.
  - abort in IDLE is ignored. If abort and in_valid are both high in IDLE, the block is accepted.
  - abort has priority over the out_ready handshake in DONE, so no output transfer is counted.
- AES_ABORT_EN undefined: no `abort` port. Only rst_n returns the FSM to IDLE.

## Test plan

- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, in_blk 00112233445566778899aabbccddeeff, bench instantiates the real datapath and key schedule.
  - Response: out_blk=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept, rk_idx sequence 0,1,…,10, rnd_last high only with rk_idx=10.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Response: out_blk stable, out_valid=1, in_ready=0, and an in_valid offered in that window is not accepted. After out_ready=1, in_ready=1 on the next cycle.
- Back-to-back:
  - Stimulus: two FIPS-197 blocks with in_valid held high and out_ready=1.
  - Response: both ciphertexts correct, second accept exactly 12 cycles after the first.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one cycle at round 5.
  - Response: next cycle IDLE, all outputs at reset values, no out_valid. A following block encrypts correctly.
- Abort (AES_ABORT_EN builds only):
  - Stimulus: abort at round 3, then abort in DONE with out_ready=1.
  - Response: IDLE on the next edge in both cases, out_valid=0, no handshake counted.
